// File: rtl/rr_slot_arbiter_pkg.sv
// Shared types and helpers for the round-robin time-slot arbiter.
// Holds the FSM encoding, default sizes and the rotating priority encoder.
package rr_slot_arbiter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int SLOT_DEF = 6;
  localparam int MAXN     = 8;
  localparam int MAXW     = 3;

  // Returns {found, index}, searching ptr, ptr+1, ... modulo n.
  function automatic logic [MAXW:0] rr_pick(
    input logic [MAXN-1:0] req,
    input logic [MAXW-1:0] ptr,
    input int              n
  );
    logic [MAXW:0]   res;
    logic [MAXW-1:0] jj;
    int              j;
    res = '0;
    for (int i = 0; i < MAXN; i++) begin
      j  = (int'(ptr) + i) % n;
      jj = MAXW'(j);
      if (i < n && !res[MAXW] && req[jj])
        res = {1'b1, jj};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_slot_timer.sv
// Modulo-SLOT up-counter bounding the length of one grant.
// Synchronous clear wins over enable.
module rr_slot_timer #(
  parameter int SLOT = 6,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_max
);

  localparam logic [CW-1:0] LAST = CW'(SLOT - 1);

  assign at_max = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter giving each owner at most SLOT cycles per grant.
// Re-arbitrates in the release cycle so grants run back to back.
import rr_slot_arbiter_pkg::*;

module rr_slot_arbiter #(
  parameter int NREQ = NREQ_DEF,
  parameter int SLOT = SLOT_DEF,
  parameter int IDW  = 2,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic [CW-1:0]   slot_count,
  output logic            slot_expire
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_inc;
  logic [IDW-1:0]  sel_ptr;
  logic [IDW-1:0]  win_id;
  logic [MAXW:0]   pick;
  logic            found;
  logic            in_grant;
  logic            owner_req;
  logic            at_max;
  logic            release_c;
  logic            load;
  logic            t_clr;
  logic            t_en;

  assign in_grant    = (state == ST_GRANT);
  assign owner_req   = |(req & gnt);
  assign release_c   = in_grant && (!owner_req || at_max);
  assign slot_expire = in_grant && owner_req && at_max;
  assign load        = !in_grant || release_c;

  // The releasing owner drops to lowest priority for this very pick.
  assign ptr_inc = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  assign sel_ptr = release_c ? ptr_inc : ptr;

  assign pick   = rr_pick(MAXN'(req), MAXW'(sel_ptr), NREQ);
  assign found  = pick[MAXW];
  assign win_id = IDW'(pick[MAXW-1:0]);

  assign t_clr = load;
  assign t_en  = in_grant;

  rr_slot_timer #(
    .SLOT (SLOT),
    .CW   (CW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .en     (t_en),
    .count  (slot_count),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else if (load) begin
      if (release_c)
        ptr <= ptr_inc;
      if (found) begin
        state     <= ST_GRANT;
        gnt       <= NREQ'(1) << win_id;
        gnt_id    <= win_id;
        gnt_valid <= 1'b1;
      end else begin
        state     <= ST_IDLE;
        gnt       <= '0;
        gnt_id    <= '0;
        gnt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed bench for rr_slot_arbiter with NREQ=4, SLOT=6.
// Each task drives one scenario and checks hand-computed values.
module tb_rr_slot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [2:0] slot_count;
  logic       slot_expire;

  int checks = 0;
  int errors = 0;

  rr_slot_arbiter #(
    .NREQ (4),
    .SLOT (6),
    .IDW  (2),
    .CW   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .slot_count  (slot_count),
    .slot_expire (slot_expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, gnt_valid, gnt_id, slot_count, slot_expire} !== 11'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b v=%b id=%0d cnt=%0d exp=%b want all 0",
               gnt, gnt_valid, gnt_id, slot_count, slot_expire);
    end
    rst_n = 1'b1;
    #1;
    req = 4'b1111;
    cyc();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1 || slot_count !== 3'd0) begin
      errors++;
      $display("FAIL first_grant: got gnt=%b id=%0d v=%b cnt=%0d want 0001 0 1 0",
               gnt, gnt_id, gnt_valid, slot_count);
    end
    cyc();
    cyc();
    checks++;
    if (slot_count !== 3'd2) begin
      errors++;
      $display("FAIL mid_count: got %0d want 2", slot_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || slot_count !== 3'd0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b id=%0d cnt=%0d v=%b want 0000 0 0 0",
               gnt, gnt_id, slot_count, gnt_valid);
    end
    req = 4'b0000;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_hold;
    do_reset();
    req = 4'b0100;
    cyc();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt !== 4'b0100 || slot_count !== 3'(i) || slot_expire !== (i == 5)) begin
        errors++;
        $display("FAIL single_hold[%0d]: got gnt=%b cnt=%0d exp=%b want 0100 %0d %b",
                 i, gnt, slot_count, slot_expire, i, (i == 5));
      end
      cyc();
    end
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1 || slot_count !== 3'd0) begin
      errors++;
      $display("FAIL single_regrant: got gnt=%b id=%0d v=%b cnt=%0d want 0100 2 1 0",
               gnt, gnt_id, gnt_valid, slot_count);
    end
  endtask

  task automatic test_rotation;
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    cyc();
    for (int s = 0; s < 5; s++) begin
      want = 4'b0001 << (s % 4);
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (gnt !== want || gnt_id !== 2'(s % 4) || slot_count !== 3'(i) ||
            slot_expire !== (i == 5)) begin
          errors++;
          $display("FAIL rotation[%0d,%0d]: got gnt=%b id=%0d cnt=%0d exp=%b want %b %0d %0d %b",
                   s, i, gnt, gnt_id, slot_count, slot_expire, want, s % 4, i, (i == 5));
        end
        cyc();
      end
    end
  endtask

  task automatic test_early_release;
    do_reset();
    req = 4'b0010;
    cyc();
    req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (gnt !== 4'b0010 || slot_count !== 3'(i) || slot_expire !== 1'b0) begin
        errors++;
        $display("FAIL early_hold[%0d]: got gnt=%b cnt=%0d exp=%b want 0010 %0d 0",
                 i, gnt, slot_count, slot_expire, i);
      end
      cyc();
    end
    req = 4'b1000;
    #1;
    checks++;
    if (slot_expire !== 1'b0 || slot_count !== 3'd2) begin
      errors++;
      $display("FAIL early_drop: got exp=%b cnt=%0d want 0 2", slot_expire, slot_count);
    end
    cyc();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || slot_count !== 3'd0) begin
      errors++;
      $display("FAIL early_next: got gnt=%b id=%0d cnt=%0d want 1000 3 0",
               gnt, gnt_id, slot_count);
    end
  endtask

  task automatic test_drop_at_limit;
    for (int i = 0; i < 5; i++) begin
      cyc();
    end
    req = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b1000 || slot_count !== 3'd5 || slot_expire !== 1'b0) begin
      errors++;
      $display("FAIL limit_drop: got gnt=%b cnt=%0d exp=%b want 1000 5 0",
               gnt, slot_count, slot_expire);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || slot_count !== 3'd0) begin
      errors++;
      $display("FAIL limit_idle: got gnt=%b v=%b id=%0d cnt=%0d want 0000 0 0 0",
               gnt, gnt_valid, gnt_id, slot_count);
    end
  endtask

  task automatic test_fairness;
    do_reset();
    req = 4'b1000;
    cyc();
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (gnt !== 4'b1000 || slot_count !== 3'(i) || slot_expire !== (i == 5)) begin
        errors++;
        $display("FAIL no_preempt[%0d]: got gnt=%b cnt=%0d exp=%b want 1000 %0d %b",
                 i, gnt, slot_count, slot_expire, i, (i == 5));
      end
      cyc();
    end
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || slot_count !== 3'd0) begin
      errors++;
      $display("FAIL fair_next: got gnt=%b id=%0d cnt=%0d want 0001 0 0",
               gnt, gnt_id, slot_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single_hold();
    test_rotation();
    test_early_release();
    test_drop_at_limit();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin time-slot arbiter that shares one datapath resource between NREQ requesters.
- Each grant lasts at most SLOT clock cycles. A wrapping slot timer, from the same counter family as the team's modulo-N counters, enforces that limit.
- Sits between the requesting clients and the shared resource. It drives the resource's select/enable from the one-hot grant.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SLOT, 6, maximum consecutive granted cycles per owner (2..2^CW).
- IDW, 2, width of the binary grant index; must satisfy 2^IDW >= NREQ.
- CW, 3, slot timer width; must satisfy 2^CW >= SLOT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held high while service is wanted.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  IDW  registered binary index of the owner; 0 when idle.
- slot_count  out  CW  current slot timer value; 0 when idle.
- slot_expire  out  1  high in the last allowed cycle of a grant whose owner still requests.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_id=0.
  - slot_count=0, slot_expire=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Reset mid-grant drops gnt immediately. No pulse completes.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0 in cycle k, the round-robin winner is selected.
  - Winner = first set req bit searching ptr, ptr+1, ..., modulo NREQ.
  - gnt/gnt_id/gnt_valid are set at edge k+1, state goes to GRANT, timer = 0.
  - If req==0, stay in IDLE.
- GRANT with owner o:
  - Timer increments by 1 each cycle.
  - Release condition in cycle c: req[o]==0, or (slot_count==SLOT-1 and req[o]==1).
  - The second case raises slot_expire in cycle c. slot_expire is combinational from the registered state and timer plus req[o].
  - On release, ptr <= (o+1) mod NREQ, so the previous owner becomes lowest priority.
  - Re-arbitration happens in the same cycle c using the updated priority order, with req sampled in cycle c.
    - If any requester wins, including o itself when o is the only requester, the new grant appears at edge c+1 with timer = 0. This gives back-to-back grants with no idle gap.
    - If req is all zero, the next state is IDLE and gnt=0 at c+1.
  - No release: gnt is unchanged and the timer advances.
- Timer: counts 0..SLOT-1, then clears on release. It never exceeds SLOT-1. Wrap-around is tied to release.
- An owner therefore holds gnt for at most SLOT consecutive cycles per grant.
- Requests from non-owners never pre-empt the owner before expiry.
- Simultaneous owner drop and timer at SLOT-1: treated as a normal drop; slot_expire=0.
- gnt is always one-hot or zero, and gnt_id is consistent with gnt.
- Requests on bits >= NREQ do not exist (the port width is exactly NREQ).

Decomposition:
- Shared package holds:
  - FSM state enum (ST_IDLE, ST_GRANT).
  - Default NREQ/SLOT constants.
  - A function for rotate-and-priority-encode (req, ptr) -> index/found.
- One sub-module, rr_slot_timer:
  - Parameters SLOT and CW.
  - Ports clk, rst_n, clr, en, count, at_max.
  - Modulo-SLOT up-counter with synchronous clear; clr has priority over en.
- The top-level arbiter holds the FSM, ptr, the grant registers and the winner selection.

Test Plan (NREQ=4, SLOT=6):
- Reset check: assert rst_n=0 mid-grant -> gnt=0, gnt_id=0, slot_count=0 immediately. After release, req=4'b1111 at k gives gnt=4'b0001 at k+1.
- Single requester holding: req=4'b0100 constant -> gnt=4'b0100 for exactly 6 cycles with slot_expire high on the 6th. Then re-granted to id 2 with no gap and slot_count restarting at 0.
- Full rotation: req=4'b1111 constant -> gnt sequence 0001,0010,0100,1000,0001, each held 6 cycles, slot_expire once per slot.
- Early release: owner id1 drops req after 2 granted cycles while req[3]=1 -> gnt=4'b1000 on the next edge, slot_expire never asserted.
- Drop at limit: owner drops req in the cycle slot_count=5 -> slot_expire=0; with no other requests the next cycle gives gnt=0, state IDLE.
- Fairness/pointer: owner 3 releases with req=4'b1001 -> next grant goes to id 0, not id 3.
